seq_alu: RTL
============

// Module: seq_alu
// PURPOSE
//  Parametrised multi-cycle ALU for the core's EX stage: single-cycle logic/shift/add ops plus
//  iterative multiply/divide (M-extension subset). One operation in flight; valid/ready on both
//  sides so the pipeline stalls while MUL/DIV iterate. Result and carry flag registered.
// PARAMETERS
//  XLEN    32              operand/result width (>=8, power of 2)
//  SHW     $clog2(XLEN)    shift-amount bits taken from B[SHW-1:0]
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     asynchronous active-low reset
//  flush      in   1     sync abort: drop op in flight / pending result
//  in_valid   in   1     operands valid
//  in_ready   out  1     block accepts op this cycle
//  A          in   XLEN  operand A
//  B          in   XLEN  operand B
//  SEL        in   4     op code (below)
//  out_valid  out  1     F/overflow valid
//  out_ready  in   1     consumer takes result
//  F          out  XLEN  result
//  overflow   out  1     ADD carry-out / SUB borrow; 0 for all other ops
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-low (rst_n).
//  Reset: state=IDLE, out_valid=0, F=0, overflow=0, iteration counter=0. in_ready=1 after reset.
//  SEL: 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SRL, 7 SRA (signed A), 8 SLL, 9 MUL (low XLEN),
//   10 MULH (signed x signed, high XLEN), 11 DIV (signed), 12 DIVU, 13 REM (signed), 14 REMU;
//   0/15 -> F=0, overflow=0, latency 1.
//  Accept: handshake when in_valid & in_ready; A/B/SEL latched at that edge.
//  in_ready = (state==IDLE) | (state==DONE & out_ready); 0 while flush=1. Back-to-back allowed.
//  FSM: IDLE -accept simple/special-> DONE; IDLE -accept MUL/DIV class-> EXEC;
//   EXEC -counter==XLEN-1-> DONE; DONE -out_ready & !accept-> IDLE; DONE -out_ready & accept-> DONE/EXEC.
//  Latency (accept edge to out_valid=1): simple ops 1 cycle; MUL/MULH/DIV*/REM* XLEN+1 cycles.
//  EXEC: one shift-add (MUL) or restoring-subtract (DIV) step per cycle; signed ops use operand
//   magnitudes, result sign fixed in final step. MULH = bits [2*XLEN-1:XLEN] of signed product.
//  ADD: {overflow,F}=A+B (XLEN+1 bit). SUB: F=A-B mod 2^XLEN, overflow=(A<B unsigned).
//  Shifts use B[SHW-1:0] only; upper B bits ignored.
//  Special cases, latency 1, no EXEC: B==0 -> DIV/DIVU F=all-ones, REM/REMU F=A;
//   DIV with A=MIN_SIGNED, B=-1 -> F=A; REM same operands -> F=0.
//  Hold: while out_valid & !out_ready, F/overflow/out_valid stable; no new accept.
//  flush=1 (any state): next edge state=IDLE, out_valid=0, counter=0; F/overflow keep old value;
//   concurrent in_valid ignored. flush has no effect on an already-IDLE block beyond in_ready=0.
//  Reset mid-EXEC: immediate return to reset values; partial result discarded.
//  in_valid while busy (EXEC, or DONE without out_ready) is not accepted; source must hold.
// TESTING
//  1 ADD A=FFFFFFFF B=00000001 -> after 1 cycle F=00000000 overflow=1; SUB 3-5 -> F=FFFFFFFE ovf=1.
//  2 SRA A=80000000 B=00000024 (shamt 4) -> F=F8000000; SRL same -> F=08000000; SLL 1<<31 -> 80000000.
//  3 MULH A=FFFFFFFF(-1) B=00000002 -> out_valid exactly 33 cycles after accept, F=FFFFFFFF;
//    MUL 7*6 -> F=0000002A.
//  4 DIV 80000000/FFFFFFFF -> F=80000000 latency 1; DIVU 5/0 -> FFFFFFFF; REM -7/2 -> FFFFFFFF.
//  5 Backpressure: out_ready=0 for 5 cycles after DIVU 100/7 -> F=0000000E held, in_ready=0;
//    out_ready=1 with in_valid ADD queued -> both handshakes same cycle, ADD result next cycle.
//  6 flush at EXEC cycle 10 of DIV -> out_valid never asserts, in_ready=1 next cycle;
//    rst_n low mid-MUL -> out_valid=0, F=0 asynchronously.

Source files
------------

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU: single-cycle logic/shift/add ops, iterative MUL/DIV
module seq_alu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [3:0]      SEL,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] F,
    output logic            overflow
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_MULH = 4'd10;
    localparam logic [3:0] OP_DIV  = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;
    localparam logic [3:0] OP_REM  = 4'd13;
    localparam logic [3:0] OP_REMU = 4'd14;

    localparam logic [XLEN-1:0] MIN_SIGNED = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]   cnt;
    logic [3:0]      op;
    logic [XLEN-1:0] hi, lo, mc;
    logic            neg;

    logic            accept;
    logic            b_zero, div_ovf, is_muldiv, is_div_sel, special, is_iter;
    logic            is_mul_sel, signed_sel, neg_n;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   sum;
    logic [XLEN-1:0] res_f;
    logic            res_o;

    logic            op_mul, last;
    logic [XLEN:0]   mul_sum, div_sh, div_tr;
    logic            div_ge;
    logic [XLEN-1:0] hi_n, lo_n, fin_f;

    assign out_valid = (state == DONE);
    assign in_ready  = !flush && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;

    // Operation classification at the input port
    assign b_zero     = (B == '0);
    assign div_ovf    = (A == MIN_SIGNED) && (B == '1);
    assign is_muldiv  = (SEL >= OP_MUL) && (SEL <= OP_REMU);
    assign is_div_sel = (SEL >= OP_DIV) && (SEL <= OP_REMU);
    assign special    = (is_div_sel && b_zero) ||
                        (((SEL == OP_DIV) || (SEL == OP_REM)) && div_ovf);
    assign is_iter    = is_muldiv && !special;
    assign is_mul_sel = (SEL == OP_MUL) || (SEL == OP_MULH);
    assign signed_sel = (SEL == OP_MULH) || (SEL == OP_DIV) || (SEL == OP_REM);
    assign a_mag      = (signed_sel && A[XLEN-1]) ? (~A + 1'b1) : A;
    assign b_mag      = (signed_sel && B[XLEN-1]) ? (~B + 1'b1) : B;

    // Remainder takes the dividend's sign; quotient and product the XOR of both
    always_comb begin
        neg_n = 1'b0;
        if ((SEL == OP_MULH) || (SEL == OP_DIV))
            neg_n = A[XLEN-1] ^ B[XLEN-1];
        else if (SEL == OP_REM)
            neg_n = A[XLEN-1];
    end

    assign sum = {1'b0, A} + {1'b0, B};

    always_comb begin
        res_f = '0;
        res_o = 1'b0;
        case (SEL)
            OP_ADD: begin
                res_f = sum[XLEN-1:0];
                res_o = sum[XLEN];
            end
            OP_SUB: begin
                res_f = A - B;
                res_o = (A < B);
            end
            OP_AND:  res_f = A & B;
            OP_OR:   res_f = A | B;
            OP_XOR:  res_f = A ^ B;
            OP_SRL:  res_f = A >> B[SHW-1:0];
            OP_SRA:  res_f = $unsigned($signed(A) >>> B[SHW-1:0]);
            OP_SLL:  res_f = A << B[SHW-1:0];
            OP_DIV, OP_DIVU: res_f = b_zero ? '1 : A;
            OP_REM, OP_REMU: res_f = b_zero ? A : '0;
            default: res_f = '0;
        endcase
    end

    // One iteration: shift-add multiply or restoring divide (hi = remainder, lo = quotient)
    assign op_mul  = (op == OP_MUL) || (op == OP_MULH);
    assign last    = (cnt == LAST);
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
    assign div_sh  = {hi, lo[XLEN-1]};
    assign div_tr  = div_sh - {1'b0, mc};
    assign div_ge  = !div_tr[XLEN];

    always_comb begin
        hi_n = hi;
        lo_n = lo;
        if (op_mul) begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo[XLEN-1:1]};
        end else begin
            hi_n = div_ge ? div_tr[XLEN-1:0] : div_sh[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], div_ge};
        end
    end

    // Sign fix on the final step; high half of -{hi,lo} is ~hi plus the carry out of ~lo+1
    always_comb begin
        fin_f = '0;
        case (op)
            OP_MUL:           fin_f = lo_n;
            OP_MULH:          fin_f = neg ? (~hi_n + XLEN'(lo_n == '0)) : hi_n;
            OP_DIV, OP_DIVU:  fin_f = neg ? (~lo_n + 1'b1) : lo_n;
            OP_REM, OP_REMU:  fin_f = neg ? (~hi_n + 1'b1) : hi_n;
            default:          fin_f = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state_n = is_iter ? EXEC : DONE;
                EXEC: if (last) state_n = DONE;
                DONE: begin
                    if (out_ready)
                        state_n = accept ? (is_iter ? EXEC : DONE) : IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            F        <= '0;
            overflow <= 1'b0;
            cnt      <= '0;
            op       <= '0;
            hi       <= '0;
            lo       <= '0;
            mc       <= '0;
            neg      <= 1'b0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            op  <= SEL;
            cnt <= '0;
            if (is_iter) begin
                hi  <= '0;
                lo  <= is_mul_sel ? b_mag : a_mag;
                mc  <= is_mul_sel ? a_mag : b_mag;
                neg <= neg_n;
            end else begin
                F        <= res_f;
                overflow <= res_o;
            end
        end else if (state == EXEC) begin
            hi <= hi_n;
            lo <= lo_n;
            if (last) begin
                cnt      <= '0;
                F        <= fin_f;
                overflow <= 1'b0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule
